mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/arb_pkg.sv | 13 +
 rtl/arb_pick.sv | 39 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for mem_port_arbiter: FSM state encoding and requester IDs.
package arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_LS = 2'd2
  } arb_state_e;

  localparam int REQ_IF = 0;
  localparam int REQ_LS = 1;

endpackage

// File: rtl/arb_pick.sv
// Two-requester pick logic: fixed LS priority, or round-robin when ARB_ROUND_ROBIN_EN is defined.
module arb_pick
  import arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       i_clk,
  input  logic       i_rst,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ARB_ROUND_ROBIN_EN
  // Set when LS was the most recent winner; reset state means fetch went last.
  logic last_ls;

  always_comb begin
    gnt = '0;
    if (req[REQ_IF] && req[REQ_LS]) begin
      if (last_ls) gnt[REQ_IF] = 1'b1;
      else         gnt[REQ_LS] = 1'b1;
    end else begin
      gnt = req;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     last_ls <= 1'b0;
    else if (|gnt) last_ls <= gnt[REQ_LS];
  end
`else
  always_comb begin
    gnt = '0;
    if (req[REQ_LS])      gnt[REQ_LS] = 1'b1;
    else if (req[REQ_IF]) gnt[REQ_IF] = 1'b1;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional round-robin tie-break selected by the ARB_ROUND_ROBIN_EN macro.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_if_req,
  input  logic [AW-1:0]   i_if_addr,
  input  logic            i_if_flush,
  output logic            o_if_gnt,
  output logic            o_if_rvalid,
  output logic [DW-1:0]   o_if_rdata,

  input  logic            i_ls_req,
  input  logic            i_ls_we,
  input  logic [DW/8-1:0] i_ls_be,
  input  logic [AW-1:0]   i_ls_addr,
  input  logic [DW-1:0]   i_ls_wdata,
  output logic            o_ls_gnt,
  output logic            o_ls_rvalid,
  output logic [DW-1:0]   o_ls_rdata,

  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [DW/8-1:0] o_mem_be,
  output logic [AW-1:0]   o_mem_addr,
  output logic [DW-1:0]   o_mem_wdata,
  input  logic            i_mem_ack,
  input  logic [DW-1:0]   i_mem_rdata
);

  arb_state_e      state_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [DW/8-1:0] mem_be_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            if_rvalid_q;
  logic            ls_rvalid_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   ls_rdata_q;
  logic            if_flushed_q;

  logic            idle_ok;
  logic [1:0]      req_v;
  logic [1:0]      gnt_v;

  // Grants are only offered from IDLE and never while reset is held.
  assign idle_ok        = (state_q == ST_IDLE) && !i_rst;
  assign req_v[REQ_IF]  = idle_ok && i_if_req && !i_if_flush;
  assign req_v[REQ_LS]  = idle_ok && i_ls_req;

  arb_pick u_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .i_clk (i_clk),
    .i_rst (i_rst),
`endif
    .req   (req_v),
    .gnt   (gnt_v)
  );

  assign o_if_gnt    = gnt_v[REQ_IF];
  assign o_ls_gnt    = gnt_v[REQ_LS];
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_ls_rvalid = ls_rvalid_q;
  // A redirect arriving in the delivery cycle still kills the fetch pulse.
  assign o_if_rvalid = if_rvalid_q && !i_if_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rvalid_q  <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
      if_flushed_q <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_v[REQ_LS]) begin
            state_q     <= ST_BUSY_LS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_ls_we;
            mem_be_q    <= i_ls_be;
            mem_addr_q  <= i_ls_addr;
            mem_wdata_q <= i_ls_wdata;
          end else if (gnt_v[REQ_IF]) begin
            state_q      <= ST_BUSY_IF;
            mem_req_q    <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '1;
            mem_addr_q   <= i_if_addr;
            mem_wdata_q  <= '0;
            if_flushed_q <= 1'b0;
          end
        end
        ST_BUSY_IF: begin
          // The memory access always runs to completion; a flush only drops the result.
          if (i_mem_ack) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            if (!(if_flushed_q || i_if_flush)) begin
              if_rdata_q  <= i_mem_rdata;
              if_rvalid_q <= 1'b1;
            end
          end else if (i_if_flush) begin
            if_flushed_q <= 1'b1;
          end
        end
        ST_BUSY_LS: begin
          if (i_mem_ack) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            ls_rdata_q  <= i_mem_rdata;
            ls_rvalid_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus flush, reset and streaming sequences.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req, i_if_flush, i_ls_req, i_ls_we, i_mem_ack;
  logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
  logic [3:0]  i_ls_be;
  logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_req, o_mem_we;
  logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_be(i_ls_be), .i_ls_addr(i_ls_addr),
    .i_ls_wdata(i_ls_wdata), .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid),
    .o_ls_rdata(o_ls_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  typedef struct {
    logic rst, if_req; logic [31:0] if_addr; logic flush, ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata; logic ack; logic [31:0] rdata;
    logic e_if_gnt, e_ls_gnt, e_mem_req, e_mem_we; logic [31:0] e_mem_addr;
    logic e_if_rv; logic [31:0] e_if_rdata; logic e_ls_rv; logic [31:0] e_ls_rdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rst, input logic ifr, input logic [31:0] ifa, input logic fl,
    input logic lsr, input logic lswe, input logic [31:0] lsa, input logic [31:0] lsd,
    input logic ack, input logic [31:0] rd,
    input logic eig, input logic elg, input logic emr, input logic ewe, input logic [31:0] ema,
    input logic eirv, input logic [31:0] eid, input logic elrv, input logic [31:0] eld);
    vec_t v;
    v.rst = rst; v.if_req = ifr; v.if_addr = ifa; v.flush = fl;
    v.ls_req = lsr; v.ls_we = lswe; v.ls_addr = lsa; v.ls_wdata = lsd;
    v.ack = ack; v.rdata = rd;
    v.e_if_gnt = eig; v.e_ls_gnt = elg; v.e_mem_req = emr; v.e_mem_we = ewe;
    v.e_mem_addr = ema; v.e_if_rv = eirv; v.e_if_rdata = eid;
    v.e_ls_rv = elrv; v.e_ls_rdata = eld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_rst = 1'b0; i_if_req = 1'b0; i_if_addr = '0; i_if_flush = 1'b0;
    i_ls_req = 1'b0; i_ls_we = 1'b0; i_ls_be = 4'hF; i_ls_addr = '0; i_ls_wdata = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1;
    logic [31:0] prev_ifd;
    int k, r, last_g;
    a1 = 32'hAAAA0001;

    // Cycle table: inputs held for one cycle, outputs checked before the next edge.
    vq.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,            0,0,0,0,0,      0,0,0,0));
    vq.push_back(mk(0,1,32'h100,0, 0,0,0,0, 0,0,      1,0,0,0,0,      0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,            0,0,1,0,32'h100, 0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,            0,0,1,0,32'h100, 0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h13,       0,0,1,0,32'h100, 0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,            0,0,0,0,0,      1,32'h13,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,            0,0,0,0,0,      0,32'h13,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'hBAD0BAD0, 0,0,0,0,0,      0,32'h13,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,            0,0,0,0,0,      0,32'h13,0,0));
    vq.push_back(mk(0,1,32'h300,0, 1,1,32'h200,32'hDEADBEEF, 0,0, 0,1,0,0,0, 0,32'h13,0,0));
    vq.push_back(mk(0,1,32'h300,0, 0,1,32'h200,32'hDEADBEEF, 1,0, 0,0,1,1,32'h200, 0,32'h13,0,0));
    vq.push_back(mk(0,1,32'h300,0, 0,0,0,0, 0,0,      1,0,0,0,0,      0,32'h13,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,a1,           0,0,1,0,32'h300, 0,32'h13,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,            0,0,0,0,0,      1,a1,0,0));
    vq.push_back(mk(0,1,32'h400,0, 1,0,32'h500,0, 0,0, 0,1,0,0,0,     0,a1,0,0));
    vq.push_back(mk(0,1,32'h400,0, 0,0,0,0, 1,32'h55, 0,0,1,0,32'h500, 0,a1,0,0));
    vq.push_back(mk(0,1,32'h400,0, 1,0,32'h600,0, 0,0, RR,!RR,0,0,0,  0,a1,1,32'h55));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,32'h77, 0,0,1,0, RR ? 32'h400 : 32'h600, 0,a1,0,32'h55));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,
                    RR, RR ? 32'h77 : a1, !RR, RR ? 32'h55 : 32'h77));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0,0,
                    0, RR ? 32'h77 : a1, 0, RR ? 32'h55 : 32'h77));

    idle_inputs();
    i_rst = 1'b1;
    tick();
    tick();

    foreach (vq[i]) begin
      i_rst = vq[i].rst; i_if_req = vq[i].if_req; i_if_addr = vq[i].if_addr;
      i_if_flush = vq[i].flush; i_ls_req = vq[i].ls_req; i_ls_we = vq[i].ls_we;
      i_ls_be = 4'hF; i_ls_addr = vq[i].ls_addr; i_ls_wdata = vq[i].ls_wdata;
      i_mem_ack = vq[i].ack; i_mem_rdata = vq[i].rdata;
      #3;
      chk($sformatf("r%0d if_gnt", i), 64'(o_if_gnt), 64'(vq[i].e_if_gnt));
      chk($sformatf("r%0d ls_gnt", i), 64'(o_ls_gnt), 64'(vq[i].e_ls_gnt));
      chk($sformatf("r%0d mem_req", i), 64'(o_mem_req), 64'(vq[i].e_mem_req));
      chk($sformatf("r%0d if_rvalid", i), 64'(o_if_rvalid), 64'(vq[i].e_if_rv));
      chk($sformatf("r%0d if_rdata", i), 64'(o_if_rdata), 64'(vq[i].e_if_rdata));
      chk($sformatf("r%0d ls_rvalid", i), 64'(o_ls_rvalid), 64'(vq[i].e_ls_rv));
      chk($sformatf("r%0d ls_rdata", i), 64'(o_ls_rdata), 64'(vq[i].e_ls_rdata));
      if (vq[i].e_mem_req || vq[i].rst) begin
        chk($sformatf("r%0d mem_we", i), 64'(o_mem_we), 64'(vq[i].e_mem_we));
        chk($sformatf("r%0d mem_addr", i), 64'(o_mem_addr), 64'(vq[i].e_mem_addr));
        chk($sformatf("r%0d mem_be", i), 64'(o_mem_be), vq[i].rst ? 64'h0 : 64'hF);
      end
      if (vq[i].e_mem_we)
        chk($sformatf("r%0d mem_wdata", i), 64'(o_mem_wdata), 64'h0000_0000_DEAD_BEEF);
      tick();
    end

    // Flush while the fetch is in flight: access completes, delivery dropped.
    prev_ifd = RR ? 32'h77 : a1;
    idle_inputs();
    i_if_req = 1'b1; i_if_addr = 32'h700;
    #3; chk("fl grant", 64'(o_if_gnt), 64'h1);
    tick();
    i_if_req = 1'b0; i_if_flush = 1'b1;
    #3; chk("fl busy mem_req", 64'(o_mem_req), 64'h1);
    tick();
    i_if_flush = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h12345678;
    #3; chk("fl no abort", 64'(o_mem_req), 64'h1);
    tick();
    i_mem_ack = 1'b0;
    #3; chk("fl rvalid", 64'(o_if_rvalid), 64'h0);
    chk("fl mem_req", 64'(o_mem_req), 64'h0);
    chk("fl rdata hold", 64'(o_if_rdata), 64'(prev_ifd));
    i_if_req = 1'b1; i_if_addr = 32'h704;
    #0; chk("fl next grant", 64'(o_if_gnt), 64'h1);
    tick();
    i_if_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hCAFE0001;
    #3; chk("fl next addr", 64'(o_mem_addr), 64'h704);
    tick();
    i_mem_ack = 1'b0;
    #3; chk("fl next rvalid", 64'(o_if_rvalid), 64'h1);
    chk("fl next rdata", 64'(o_if_rdata), 64'hCAFE0001);
    tick();
    // Flush coinciding with the ack.
    i_if_req = 1'b1; i_if_addr = 32'h708;
    #3; chk("fa grant", 64'(o_if_gnt), 64'h1);
    tick();
    i_if_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h1111; i_if_flush = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_if_flush = 1'b0;
    #3; chk("fa rvalid", 64'(o_if_rvalid), 64'h0);
    tick();
    // Flush in the delivery cycle.
    i_if_req = 1'b1; i_if_addr = 32'h70C;
    #3; chk("fr grant", 64'(o_if_gnt), 64'h1);
    tick();
    i_if_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h2222;
    tick();
    i_mem_ack = 1'b0; i_if_flush = 1'b1;
    #3; chk("fr rvalid", 64'(o_if_rvalid), 64'h0);
    tick();
    i_if_flush = 1'b0;

    // Reset during a load/store, with a late ack afterwards.
    i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 32'h800;
    #3; chk("rs ls grant", 64'(o_ls_gnt), 64'h1);
    tick();
    i_ls_req = 1'b0;
    #3; chk("rs busy mem_req", 64'(o_mem_req), 64'h1);
    i_rst = 1'b1; i_if_req = 1'b1; i_if_addr = 32'h900;
    tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h99;
    #3; chk("rs mem_req drop", 64'(o_mem_req), 64'h0);
    chk("rs no gnt in rst", 64'(o_if_gnt), 64'h0);
    tick();
    i_rst = 1'b0; i_if_req = 1'b0;
    #3; chk("rs ls_rvalid", 64'(o_ls_rvalid), 64'h0);
    chk("rs ls_rdata", 64'(o_ls_rdata), 64'h0);
    chk("rs if_rdata", 64'(o_if_rdata), 64'h0);
    tick();
    i_mem_ack = 1'b0;
    #3; chk("rs late ack", 64'(o_ls_rvalid), 64'h0);
    chk("rs idle mem_req", 64'(o_mem_req), 64'h0);
    tick();

    // Streaming fetches against a zero-wait memory.
    k = 0; r = 0; last_g = -1;
    for (int cyc = 0; cyc < 40 && r < 8; cyc++) begin
      i_if_req = (k < 8);
      i_if_addr = 32'h1000 + 32'(4 * k);
      i_mem_ack = o_mem_req;
      i_mem_rdata = {16'hF0F0, o_mem_addr[15:0]};
      #3;
      if (o_if_gnt) begin
        if (last_g >= 0) chk("st spacing", 64'(cyc - last_g), 64'd2);
        last_g = cyc;
        k++;
      end
      if (o_if_rvalid) begin
        chk($sformatf("st rdata%0d", r), 64'(o_if_rdata), 64'({16'hF0F0, 16'h1000 + 16'(4 * r)}));
        r++;
      end
      tick();
    end
    chk("st count", 64'(r), 64'd8);
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
